// File: rtl/clock_divide_select_nch.sv
`timescale 1ns/1ps
// clock_divide_select_nch
//
// N-channel programmable clock divider with glitch-free output selection.
// Every channel runs a down-counter and a toggle flop. The half-period of
// channel i is (F_i + 1) source cycles. A three-state switch-over machine
// (RUN -> DRAIN -> HOLD -> RUN) moves the output from one channel to another.
// The old channel's last high pulse and the new channel's first high pulse
// are never truncated.
//
// Ports
//   clk        divider source clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   en         global enable; 0 stops every channel and forces it low
//   div_factor packed per-channel factors, channel i at [i*DIV_W +: DIV_W]
//   sel        requested output channel; values >= NUM_CH are ignored
//   clk_out    registered, selected divided clock
//   busy       high while a channel switch is in progress
//   cur_sel    channel currently driving clk_out
module clock_divide_select_nch #(
    parameter int  NUM_CH = 4,
    parameter int  DIV_W  = 6,
    localparam int SEL_W  = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH*DIV_W-1:0] div_factor,
    input  logic [SEL_W-1:0]        sel,
    output logic                    clk_out,
    output logic                    busy,
    output logic [SEL_W-1:0]        cur_sel
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    logic [DIV_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] ch;

    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  tgt;
    logic [SEL_W-1:0]  tgt_nxt;
    logic [SEL_W-1:0]  cur_sel_nxt;
    logic              clk_out_nxt;

    logic              sel_vld;
    logic              ch_cur;
    logic              ch_tgt;

    // ---- Channel dividers ----
    // The factor is sampled only at the toggle instant. Changing it
    // mid-half-period therefore never shortens or stretches the phase
    // already in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            ch <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!en) begin
                    cnt[i] <= '0;
                    ch[i]  <= 1'b0;
                end else if (cnt[i] == '0) begin
                    ch[i]  <= ~ch[i];
                    cnt[i] <= div_factor[i*DIV_W +: DIV_W];
                end else begin
                    cnt[i] <= cnt[i] - DIV_W'(1);
                end
            end
        end
    end

    // Out-of-range requests are treated as "no change".
    assign sel_vld = (32'(sel) < NUM_CH);
    assign ch_cur  = ch[cur_sel];
    assign ch_tgt  = ch[tgt];

    // ---- Switch-over FSM: next state ----
    // DRAIN waits for the old channel to go low, so its last high pulse
    // finishes. HOLD keeps the output low until the new channel is low.
    // The new channel's next rising edge then starts a full pulse.
    always_comb begin
        state_nxt   = state;
        tgt_nxt     = tgt;
        cur_sel_nxt = cur_sel;
        clk_out_nxt = 1'b0;
        case (state)
            S_RUN: begin
                clk_out_nxt = ch_cur;
                if (sel_vld && (sel != cur_sel)) begin
                    tgt_nxt   = sel;
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                clk_out_nxt = ch_cur;
                if (sel == cur_sel) begin
                    state_nxt = S_RUN;
                end else begin
                    if (sel_vld) begin
                        tgt_nxt = sel;
                    end
                    if (!ch_cur) begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!ch_tgt) begin
                    cur_sel_nxt = tgt;
                    state_nxt   = S_RUN;
                end else if (sel_vld && (sel != cur_sel)) begin
                    tgt_nxt = sel;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // ---- Switch-over FSM: registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_RUN;
            tgt     <= '0;
            cur_sel <= '0;
            clk_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            tgt     <= tgt_nxt;
            cur_sel <= cur_sel_nxt;
            clk_out <= clk_out_nxt;
        end
    end

    assign busy = (state != S_RUN);

endmodule

// File: tb/tb_clock_divide_select_nch.sv
`timescale 1ns/1ps
// Directed testbench for clock_divide_select_nch.
// The main instance uses 4 channels. A second instance with 3 channels
// covers out-of-range select values.
module tb_clock_divide_select_nch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [23:0] div_factor = '0;
    logic [1:0]  sel = '0;
    logic        clk_out;
    logic        busy;
    logic [1:0]  cur_sel;

    logic [17:0] div_factor3 = '0;
    logic [1:0]  sel3 = '0;
    logic        clk_out3;
    logic        busy3;
    logic [1:0]  cur_sel3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clock_divide_select_nch #(.NUM_CH(4), .DIV_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_factor (div_factor),
        .sel        (sel),
        .clk_out    (clk_out),
        .busy       (busy),
        .cur_sel    (cur_sel)
    );

    clock_divide_select_nch #(.NUM_CH(3), .DIV_W(6)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_factor (div_factor3),
        .sel        (sel3),
        .clk_out    (clk_out3),
        .busy       (busy3),
        .cur_sel    (cur_sel3)
    );

    // Pulse reset; the next rising edge is edge 1 of the following test.
    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        div_factor  = '0;
        div_factor3 = '0;
        sel  = 2'd0;
        sel3 = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_clk_out: got %b expected 0", clk_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (cur_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cur_sel: got %0d expected 0", cur_sel);
        end
        n_checks++;
        if (busy3 !== 1'b0 || clk_out3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut3: got busy=%b clk_out=%b expected 0/0", busy3, clk_out3);
        end
        rst = 1'b0;
    endtask

    task automatic test_div_by_two();
        logic [1:8] exp_clk;
        exp_clk = 8'b01010101;
        div_factor = '0;
        sel = 2'd0;
        en  = 1'b1;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (clk_out !== exp_clk[k]) begin
                n_fail++;
                $display("FAIL div2_clk_out edge %0d: got %b expected %b", k, clk_out, exp_clk[k]);
            end
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL div2_busy edge %0d: got %b expected 0", k, busy);
            end
        end
    endtask

    task automatic test_factor_change();
        logic [1:21] exp_clk;
        exp_clk = 21'b0_1111_0000_1111_0011_0011;
        div_factor = {6'd0, 6'd0, 6'd0, 6'd3};
        sel = 2'd0;
        apply_reset();
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (clk_out !== exp_clk[k]) begin
                n_fail++;
                $display("FAIL factor_clk_out edge %0d: got %b expected %b", k, clk_out, exp_clk[k]);
            end
            if (k == 10) div_factor = {6'd0, 6'd0, 6'd0, 6'd1};
        end
    endtask

    task automatic test_switch();
        logic [1:21] exp_clk;
        logic [1:21] exp_busy;
        logic [1:0]  exp_sel;
        exp_clk  = 21'b0_111_000_111_000_111111_00;
        exp_busy = 21'b00000000_111_0000000000;
        div_factor = {6'd0, 6'd1, 6'd5, 6'd2};
        sel = 2'd0;
        apply_reset();
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            exp_sel = (k >= 12) ? 2'd1 : 2'd0;
            n_checks++;
            if (clk_out !== exp_clk[k]) begin
                n_fail++;
                $display("FAIL switch_clk_out edge %0d: got %b expected %b", k, clk_out, exp_clk[k]);
            end
            n_checks++;
            if (busy !== exp_busy[k]) begin
                n_fail++;
                $display("FAIL switch_busy edge %0d: got %b expected %b", k, busy, exp_busy[k]);
            end
            n_checks++;
            if (cur_sel !== exp_sel) begin
                n_fail++;
                $display("FAIL switch_cur_sel edge %0d: got %0d expected %0d", k, cur_sel, exp_sel);
            end
            if (k == 8) sel = 2'd1;
        end
        sel = 2'd0;
    endtask

    task automatic test_cancel();
        logic [1:16] exp_clk;
        logic [1:16] exp_busy;
        exp_clk  = 16'b0_111_000_111_000_111;
        exp_busy = 16'b0000_0000_1000_0000;
        div_factor = {6'd0, 6'd4, 6'd5, 6'd2};
        sel = 2'd0;
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (clk_out !== exp_clk[k]) begin
                n_fail++;
                $display("FAIL cancel_clk_out edge %0d: got %b expected %b", k, clk_out, exp_clk[k]);
            end
            n_checks++;
            if (busy !== exp_busy[k]) begin
                n_fail++;
                $display("FAIL cancel_busy edge %0d: got %b expected %b", k, busy, exp_busy[k]);
            end
            n_checks++;
            if (cur_sel !== 2'd0) begin
                n_fail++;
                $display("FAIL cancel_cur_sel edge %0d: got %0d expected 0", k, cur_sel);
            end
            if (k == 8) sel = 2'd2;
            if (k == 9) sel = 2'd0;
        end
    endtask

    task automatic test_invalid_sel();
        div_factor3 = '0;
        sel3 = 2'd3;
        apply_reset();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (busy3 !== 1'b0 || cur_sel3 !== 2'd0) begin
                n_fail++;
                $display("FAIL invalid_sel edge %0d: got busy=%b cur_sel=%0d expected 0/0", k, busy3, cur_sel3);
            end
            n_checks++;
            if (clk_out3 !== ((k % 2) == 0)) begin
                n_fail++;
                $display("FAIL invalid_sel_clk_out edge %0d: got %b expected %b", k, clk_out3, ((k % 2) == 0));
            end
        end
        sel3 = 2'd2;
        for (int k = 11; k <= 15; k++) begin
            @(posedge clk);
            #1;
            if (k == 11 || k == 14) begin
                n_checks++;
                if (busy3 !== 1'b1 || cur_sel3 !== 2'd0) begin
                    n_fail++;
                    $display("FAIL sel3_pending edge %0d: got busy=%b cur_sel=%0d expected 1/0", k, busy3, cur_sel3);
                end
            end
            if (k == 15) begin
                n_checks++;
                if (busy3 !== 1'b0 || cur_sel3 !== 2'd2) begin
                    n_fail++;
                    $display("FAIL sel3_done edge %0d: got busy=%b cur_sel=%0d expected 0/2", k, busy3, cur_sel3);
                end
            end
        end
        sel3 = 2'd0;
    endtask

    task automatic test_rst_hold_and_enable();
        logic [1:8] exp_clk;
        exp_clk = 8'b0111_0001;
        div_factor = {6'd0, 6'd1, 6'd5, 6'd2};
        sel = 2'd0;
        en  = 1'b1;
        apply_reset();
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            if (k == 8)  sel = 2'd1;
            if (k == 15) sel = 2'd0;
        end
        // Switch 1 -> 0 is parked in HOLD waiting for channel 0 to fall.
        n_checks++;
        if (busy !== 1'b1 || cur_sel !== 2'd1 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_state: got busy=%b cur_sel=%0d clk_out=%b expected 1/1/0", busy, cur_sel, clk_out);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (clk_out !== 1'b0 || busy !== 1'b0 || cur_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_in_hold: got clk_out=%b busy=%b cur_sel=%0d expected 0/0/0", clk_out, busy, cur_sel);
        end
        en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (clk_out !== 1'b0 || busy !== 1'b0 || clk_out3 !== 1'b0) begin
                n_fail++;
                $display("FAIL en_low edge %0d: got clk_out=%b busy=%b clk_out3=%b expected 0/0/0", k, clk_out, busy, clk_out3);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (clk_out !== exp_clk[k]) begin
                n_fail++;
                $display("FAIL reenable_clk_out edge %0d: got %b expected %b", k, clk_out, exp_clk[k]);
            end
        end
        // Dropping en while channel 0 is high: one registered 1, then low.
        en = 1'b0;
        for (int k = 9; k <= 11; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (clk_out !== (k == 9)) begin
                n_fail++;
                $display("FAIL en_drop_clk_out edge %0d: got %b expected %b", k, clk_out, (k == 9));
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_div_by_two();
        test_factor_change();
        test_switch();
        test_cancel();
        test_invalid_sel();
        test_rst_hold_and_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
